// File: rtl/serial_tx_if.sv
// Bus bundle between the CPU-side serial logic and the mode 2/3 transmit sequencer.
// The master drives the baud strobe, mode bits and SBUF writes; the slave returns line and status.
interface serial_tx_if;
   logic       serial_br_i;
   logic       serial_scon7_sm0_i;
   logic       serial_scon3_tb8_i;
   logic       serial_sbuf_write_i;
   logic [7:0] serial_sbuf_data_i;
   logic       serial_txd_o;
   logic       serial_p3en_1_o;
   logic       serial_scon1_ti_o;
   logic       serial_busy_o;
   logic       serial_collision_o;

   modport master (
      output serial_br_i, serial_scon7_sm0_i, serial_scon3_tb8_i,
             serial_sbuf_write_i, serial_sbuf_data_i,
      input  serial_txd_o, serial_p3en_1_o, serial_scon1_ti_o,
             serial_busy_o, serial_collision_o
   );

   modport slave (
      input  serial_br_i, serial_scon7_sm0_i, serial_scon3_tb8_i,
             serial_sbuf_write_i, serial_sbuf_data_i,
      output serial_txd_o, serial_p3en_1_o, serial_scon1_ti_o,
             serial_busy_o, serial_collision_o
   );
endinterface

// File: rtl/serial_tx_control.sv
// Serial port transmit sequencer for 9-bit asynchronous modes (2/3): start, 8 data LSB first,
// TB8, stop, each bit lasting BR_PER_BIT rising edges of the shared baud strobe.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line high, pad released, waiting for an SBUF write with SM0 = 1
// SYNC   | frame latched, pad driven high, waiting for a baud tick to align
// START  | start bit (0)
// DATA   | data bits, shift register bit 0 on the line
// NINTH  | TB8 on the line
// STOP   | stop bit (1); TI requested on entry
module serial_tx_control #(
   parameter int BR_PER_BIT = 16,
   parameter int CNT_W      = 6
) (
   input  logic         serial_clock_i,
   input  logic         serial_reset_i,
   serial_tx_if.slave   tx
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_START,
      ST_DATA,
      ST_NINTH,
      ST_STOP
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BR_PER_BIT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [8:0]       shreg_q, shreg_d;
   logic             br_q, br_d;
   logic             tick_q, tick_d;
   logic             txd_q, txd_d;
   logic             p3en_q, p3en_d;
   logic             ti_q, ti_d;
   logic             busy_q, busy_d;
   logic             col_q, col_d;
   logic             bit_end;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      ti_d      = 1'b0;
      col_d     = 1'b0;
      br_d      = tx.serial_br_i;
      tick_d    = tx.serial_br_i & ~br_q;
      bit_end   = tick_q && (cnt_q == CNT_LAST);

      case (state_q)
         ST_IDLE: begin
            if (tx.serial_sbuf_write_i && tx.serial_scon7_sm0_i) begin
               shreg_d   = {tx.serial_scon3_tb8_i, tx.serial_sbuf_data_i};
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = ST_SYNC;
            end
         end
         ST_SYNC: begin
            if (tick_q) begin
               cnt_d   = '0;
               state_d = ST_START;
            end
         end
         default: begin
            if (bit_end) begin
               cnt_d = '0;
               case (state_q)
                  ST_START: begin
                     bit_idx_d = '0;
                     state_d   = ST_DATA;
                  end
                  ST_DATA: begin
                     // after eight shifts TB8 sits in bit 0, so NINTH reads the same bit
                     shreg_d   = {1'b0, shreg_q[8:1]};
                     bit_idx_d = bit_idx_q + 1'b1;
                     if (bit_idx_q == 3'd7) state_d = ST_NINTH;
                  end
                  ST_NINTH: begin
                     ti_d    = 1'b1;
                     state_d = ST_STOP;
                  end
                  default: state_d = ST_IDLE;
               endcase
            end else if (tick_q) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase

      if (state_q != ST_IDLE) begin
         if (tx.serial_sbuf_write_i) col_d = 1'b1;
         if (!tx.serial_scon7_sm0_i) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            bit_idx_d = '0;
            ti_d      = 1'b0;
         end
      end

      busy_d = (state_d != ST_IDLE);
      p3en_d = busy_d;
      case (state_d)
         ST_START:          txd_d = 1'b0;
         ST_DATA, ST_NINTH: txd_d = shreg_d[0];
         default:           txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge serial_clock_i) begin
      if (serial_reset_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         br_q      <= 1'b1;
         tick_q    <= 1'b0;
         txd_q     <= 1'b1;
         p3en_q    <= 1'b0;
         ti_q      <= 1'b0;
         busy_q    <= 1'b0;
         col_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         br_q      <= br_d;
         tick_q    <= tick_d;
         txd_q     <= txd_d;
         p3en_q    <= p3en_d;
         ti_q      <= ti_d;
         busy_q    <= busy_d;
         col_q     <= col_d;
      end
   end

   assign tx.serial_txd_o       = txd_q;
   assign tx.serial_p3en_1_o    = p3en_q;
   assign tx.serial_scon1_ti_o  = ti_q;
   assign tx.serial_busy_o      = busy_q;
   assign tx.serial_collision_o = col_q;

endmodule

// File: tb/tb_serial_tx_control.sv
// Directed bench for serial_tx_control: a table of frames with hand-computed line patterns,
// plus in-frame collision, abort, reset and back-to-back sequences.
module tb_serial_tx_control;

   localparam int ACT_NONE     = 0;
   localparam int ACT_COLL     = 1;
   localparam int ACT_ABORT    = 2;
   localparam int ACT_RESET    = 3;
   localparam int ACT_COLL_END = 4;
   localparam int BIT_CLKS     = 256;

   typedef struct {
      logic [7:0]  data;
      logic        tb8;
      logic [10:0] exp;
      int          act;
      int          act_bit;
      int          exp_col;
      bit          chain;
      bit          gap;
   } vec_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   br_ph = 0;
   int   last_rise = 0;
   int   ti_cnt = 0;
   int   last_ti_cyc = 0;
   int   col_cnt = 0;
   int   pb_err = 0;
   int   idle_err = 0;
   int   prev_c0 = 0;
   int   total = 0;
   int   bad = 0;
   vec_t vecs[10];

   serial_tx_if bus ();

   serial_tx_control #(.BR_PER_BIT(16), .CNT_W(6)) dut (
      .serial_clock_i (clk),
      .serial_reset_i (rst),
      .tx             (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // baud strobe: 16 clocks per period, 8 high / 8 low
   always @(negedge clk) begin
      br_ph = (br_ph + 1) % 16;
      bus.serial_br_i = (br_ph < 8);
      if (br_ph == 0) last_rise = cyc;
   end

   always @(negedge clk) begin
      if (bus.serial_scon1_ti_o === 1'b1) begin
         ti_cnt++;
         last_ti_cyc = cyc;
      end
      if (bus.serial_collision_o === 1'b1) col_cnt++;
      if (bus.serial_p3en_1_o !== bus.serial_busy_o) pb_err++;
      if (bus.serial_busy_o === 1'b0 && bus.serial_txd_o !== 1'b1) idle_err++;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic pulse_write(input logic [7:0] d, input logic t8);
      bus.serial_sbuf_data_i  = d;
      bus.serial_scon3_tb8_i  = t8;
      bus.serial_sbuf_write_i = 1'b1;
      @(negedge clk);
      bus.serial_sbuf_write_i = 1'b0;
   endtask

   task automatic run_frame(input int k, input vec_t v);
      int ti0, col0, c0, n;
      ti0  = ti_cnt;
      col0 = col_cnt;
      pulse_write(v.data, v.tb8);
      bus.serial_sbuf_data_i = ~v.data;
      bus.serial_scon3_tb8_i = ~v.tb8;
      chk($sformatf("busy_rise_f%0d", k), bus.serial_busy_o, 1);
      chk($sformatf("p3en_rise_f%0d", k), bus.serial_p3en_1_o, 1);
      chk($sformatf("txd_sync_f%0d", k), bus.serial_txd_o, 1);
      n = 0;
      while (bus.serial_txd_o !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (bus.serial_txd_o !== 1'b0) begin
         chk($sformatf("start_fall_f%0d", k), bus.serial_txd_o, 0);
         return;
      end
      c0 = cyc;
      chk($sformatf("sync_align_f%0d", k), c0 - last_rise, 2);
      if (v.gap) chk($sformatf("b2b_gap_f%0d", k), c0 - prev_c0, 11 * BIT_CLKS + 16);
      prev_c0 = c0;

      for (int i = 0; i < 11; i++) begin
         wait_until(c0 + i * BIT_CLKS + BIT_CLKS / 2);
         chk($sformatf("bit%0d_f%0d", i, k), bus.serial_txd_o, v.exp[i]);
         if (v.act_bit == i) begin
            if (v.act == ACT_COLL) begin
               pulse_write(8'h3C, 1'b0);
            end else if (v.act == ACT_ABORT) begin
               bus.serial_scon7_sm0_i = 1'b0;
               @(negedge clk);
               chk($sformatf("abort_txd_f%0d", k), bus.serial_txd_o, 1);
               chk($sformatf("abort_busy_f%0d", k), bus.serial_busy_o, 0);
               chk($sformatf("abort_p3en_f%0d", k), bus.serial_p3en_1_o, 0);
               bus.serial_scon7_sm0_i = 1'b1;
               repeat (16) @(negedge clk);
               chk($sformatf("abort_ti_f%0d", k), ti_cnt - ti0, 0);
               return;
            end else if (v.act == ACT_RESET) begin
               rst = 1'b1;
               @(negedge clk);
               chk($sformatf("rst_txd_f%0d", k), bus.serial_txd_o, 1);
               chk($sformatf("rst_p3en_f%0d", k), bus.serial_p3en_1_o, 0);
               chk($sformatf("rst_ti_f%0d", k), bus.serial_scon1_ti_o, 0);
               chk($sformatf("rst_busy_f%0d", k), bus.serial_busy_o, 0);
               chk($sformatf("rst_col_f%0d", k), bus.serial_collision_o, 0);
               chk($sformatf("rst_ti_cnt_f%0d", k), ti_cnt - ti0, 0);
               rst = 1'b0;
               return;
            end
         end
      end

      if (v.act == ACT_COLL_END) begin
         wait_until(c0 + 11 * BIT_CLKS - 1);
         chk($sformatf("stop_busy_f%0d", k), bus.serial_busy_o, 1);
         pulse_write(8'h3C, 1'b1);
      end
      n = 0;
      while (bus.serial_busy_o !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("frame_end_f%0d", k), cyc - c0, 11 * BIT_CLKS);
      chk($sformatf("ti_count_f%0d", k), ti_cnt - ti0, 1);
      chk($sformatf("ti_pos_f%0d", k), last_ti_cyc - c0, 10 * BIT_CLKS);
      if (!v.chain) begin
         repeat (40) @(negedge clk);
         chk($sformatf("no_refire_f%0d", k), bus.serial_busy_o, 0);
      end
      chk($sformatf("col_count_f%0d", k), col_cnt - col0, v.exp_col);
   endtask

   initial begin
      int col0;
      vecs[0] = '{8'hA5, 1'b1, 11'b11101001010, ACT_NONE,     -1, 0, 1'b0, 1'b0};
      vecs[1] = '{8'h00, 1'b0, 11'b10000000000, ACT_NONE,     -1, 0, 1'b0, 1'b0};
      vecs[2] = '{8'hA5, 1'b1, 11'b11101001010, ACT_COLL,      4, 1, 1'b0, 1'b0};
      vecs[3] = '{8'h96, 1'b1, 11'b11100101100, ACT_ABORT,     6, 0, 1'b0, 1'b0};
      vecs[4] = '{8'h5A, 1'b0, 11'b10010110100, ACT_NONE,     -1, 0, 1'b0, 1'b0};
      vecs[5] = '{8'hC3, 1'b1, 11'b11110000110, ACT_RESET,     9, 0, 1'b0, 1'b0};
      vecs[6] = '{8'h0F, 1'b0, 11'b10000011110, ACT_NONE,     -1, 0, 1'b0, 1'b0};
      vecs[7] = '{8'hA5, 1'b1, 11'b11101001010, ACT_COLL_END, -1, 1, 1'b0, 1'b0};
      vecs[8] = '{8'hFF, 1'b0, 11'b10111111110, ACT_NONE,     -1, 0, 1'b1, 1'b0};
      vecs[9] = '{8'h55, 1'b0, 11'b10010101010, ACT_NONE,     -1, 0, 1'b0, 1'b1};

      rst = 1'b1;
      bus.serial_scon7_sm0_i  = 1'b0;
      bus.serial_scon3_tb8_i  = 1'b0;
      bus.serial_sbuf_write_i = 1'b0;
      bus.serial_sbuf_data_i  = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_txd", bus.serial_txd_o, 1);
      chk("reset_p3en", bus.serial_p3en_1_o, 0);
      chk("reset_ti", bus.serial_scon1_ti_o, 0);
      chk("reset_busy", bus.serial_busy_o, 0);
      chk("reset_col", bus.serial_collision_o, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      col0 = col_cnt;
      pulse_write(8'h77, 1'b1);
      repeat (40) @(negedge clk);
      chk("sm0_off_busy", bus.serial_busy_o, 0);
      chk("sm0_off_col", col_cnt - col0, 0);

      bus.serial_scon7_sm0_i = 1'b1;
      repeat (5) @(negedge clk);

      for (int k = 0; k < 10; k++) run_frame(k, vecs[k]);

      repeat (5) @(negedge clk);
      chk("p3en_eq_busy", pb_err, 0);
      chk("idle_txd_high", idle_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
